cordic_vector_iter: RTL and testbench

- Iterative CORDIC engine in vectoring mode, the inverse direction of the pipelined rotation stages.
- Takes a Cartesian vector (x, y) and drives y to zero one micro-rotation per clock, accumulating the rotation angle.
- Produces atan2(y, x) and the gain-scaled magnitude K·sqrt(x²+y²).
- Sits behind a valid/ready request port and a valid/ready result port for use by the peripheral's register front-end.

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/cordic_atan_rom.sv | 18 +
 rtl/cordic_vector_iter.sv | 78 +++++++
 tb/tb_cordic_vector_iter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC word format, pi/gain constants, atan table generator and engine state enum
package cordic_pkg;
  localparam int CORDIC_Q = 4;
  localparam int CORDIC_F = 36;
  typedef logic signed [CORDIC_Q+CORDIC_F-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [63:0] PI60 = 64'h3243F6A8885A308D;
  localparam logic [63:0] K_F36 = 64'd113164503248;
  function automatic logic [63:0] to_q(input logic [63:0] v, input int f);
    return (v + (64'd1 << (59 - f))) >> (60 - f);
  endfunction
  function automatic logic [63:0] atan60(input int i);
    logic [63:0] s;
    s = 64'd0;
    for (int n = 1; n <= 59; n += 2)
      if (i * n <= 60)
        s = (n % 4 == 1) ? s + ((64'd1 << (60 - i * n)) / 64'(n)) : s - ((64'd1 << (60 - i * n)) / 64'(n));
    return (i == 0) ? PI60 >> 2 : s;
  endfunction
  localparam word_t PI = word_t'(to_q(PI60, CORDIC_F));
  localparam word_t PI_2 = word_t'(to_q(PI60 >> 1, CORDIC_F));
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: idx -> atan(2^-idx) in Q(W-F).F, constant table, combinational read
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = 40,
  parameter int F = 36,
  parameter int ITER = 20,
  parameter int IW = $clog2(ITER)
) (
  input  logic [IW-1:0]       idx,
  output logic signed [W-1:0] atan
);
  logic signed [W-1:0] tbl [ITER];
  for (genvar i = 0; i < ITER; i++) begin : g_tbl
    assign tbl[i] = W'(to_q(atan60(i), F));
  end
  assign atan = tbl[idx];
endmodule

// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter: iterative vectoring CORDIC, (x_in,y_in) req port -> (mag_out=K|v|, angle_out=atan2) result port
module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int Q = CORDIC_Q,
  parameter int F = CORDIC_F,
  parameter int STAGES = 5,
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [Q+F-1:0] x_in,
  input  logic signed [Q+F-1:0] y_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Q+F-1:0] mag_out,
  output logic signed [Q+F-1:0] angle_out
);
  localparam int W = Q + F;
  localparam int ITER = STAGES * N;
  localparam int IW = $clog2(ITER);
  localparam logic signed [W-1:0] PI_2_Q = W'(to_q(PI60 >> 1, F));
  state_t state, state_nx;
  logic signed [W-1:0] x, y, z, x_nx, y_nx, z_nx, x_pre, y_pre, z_pre, xs, ys, atan_i;
  logic [IW-1:0] iter, iter_nx;
  cordic_atan_rom #(.W(W), .F(F), .ITER(ITER), .IW(IW)) u_rom (.idx(iter), .atan(atan_i));
  assign xs = x >>> iter;
  assign ys = y >>> iter;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign mag_out = x;
  assign angle_out = z;
  always_comb begin
    x_pre = x_in[W-1] ? (y_in[W-1] ? -y_in : y_in) : x_in;
    y_pre = x_in[W-1] ? (y_in[W-1] ? x_in : -x_in) : y_in;
    z_pre = x_in[W-1] ? (y_in[W-1] ? -PI_2_Q : PI_2_Q) : '0;
  end
  always_comb begin
    state_nx = state;
    x_nx = x;
    y_nx = y;
    z_nx = z;
    iter_nx = iter;
    case (state)
      IDLE: if (in_valid) begin
        state_nx = RUN;
        x_nx = x_pre;
        y_nx = y_pre;
        z_nx = z_pre;
        iter_nx = '0;
      end
      RUN: begin
        x_nx = y[W-1] ? x - ys : x + ys;
        y_nx = y[W-1] ? y + xs : y - xs;
        z_nx = y[W-1] ? z - atan_i : z + atan_i;
        iter_nx = iter + 1'b1;
        state_nx = (iter == IW'(ITER - 1)) ? DONE : RUN;
      end
      default: state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      z <= '0;
      iter <= '0;
    end else begin
      state <= state_nx;
      x <= x_nx;
      y <= y_nx;
      z <= z_nx;
      iter <= iter_nx;
    end
endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb_cordic_vector_iter: directed self-checking bench for cordic_vector_iter
module tb_cordic_vector_iter;
  localparam int W = 40;
  localparam real S = 68719476736.0;
  localparam real TA = 7.62939453125e-6;
  localparam real TM = 1.52587890625e-5;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [W-1:0] x_in = '0, y_in = '0, mag_out, angle_out;
  logic signed [W-1:0] m_hold, a_hold;
  logic stable;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cordic_vector_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .mag_out(mag_out), .angle_out(angle_out)
  );
  function automatic logic signed [W-1:0] toq(input real r);
    return W'(longint'(r * S));
  endfunction
  function automatic real tor(input logic signed [W-1:0] v);
    return real'(longint'(v)) / S;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
    checks++;
    assert ((obs >= exp - tol && obs <= exp + tol) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask
  task automatic start(input real xr, input real yr);
    chk("accept_ready", in_ready, 1);
    x_in = toq(xr);
    y_in = toq(yr);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_in = toq(-1.9);
    y_in = toq(0.7);
  endtask
  task automatic finish(input string tag, input real me, input real ae);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd20);
    chk({tag, "_busy"}, in_ready, 0);
    chk_near({tag, "_mag"}, tor(mag_out), me, TM);
    chk_near({tag, "_angle"}, tor(angle_out), ae, TA);
  endtask
  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_idle", in_ready, 1);
    chk("consume_valid", out_valid, 0);
  endtask
  initial begin
    tick(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mag", mag_out, 0);
    chk("rst_angle", angle_out, 0);
    rst_n = 1'b1;
    start(1.0, 1.0);
    tick(5);
    chk("midrun_busy", in_ready, 0);
    rst_n = 1'b0;
    tick();
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_mag", mag_out, 0);
    chk("abort_angle", angle_out, 0);
    rst_n = 1'b1;
    start(1.0, 0.0);
    finish("x1y0", 1.6467602581, 0.0);
    consume();
    start(1.0, 1.0);
    finish("x1y1", 2.3288706869, 0.7853981634);
    consume();
    out_ready = 1'b1;
    start(-1.0, 0.0);
    finish("xm1y0", 1.6467602581, 3.1415926536);
    tick();
    out_ready = 1'b0;
    chk("ready_high_idle", in_ready, 1);
    start(-0.5, -0.5);
    finish("xmhymh", 1.1644353435, -2.3561944902);
    m_hold = mag_out;
    a_hold = angle_out;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      x_in = toq(0.3);
      y_in = toq(-0.2);
      tick();
      stable &= (mag_out === m_hold) && (angle_out === a_hold) && out_valid && !in_ready;
    end
    in_valid = 1'b0;
    chk("bp_stable", stable, 1);
    consume();
    start(1.0, 0.0);
    finish("after_bp", 1.6467602581, 0.0);
    consume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
